// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-add multiplier around one four_bit_full_adder.
// Optional macro SHIFT_ADD_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
`default_nettype none

module four_bit_full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module shift_add_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_mcand, w_mcand_nxt;
  logic [7:0] r_p, w_p_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_product, w_product_nxt;

  logic [3:0] w_add_b;
  logic [3:0] w_sum;
  logic       w_cout;
  logic [7:0] w_p_iter;
  logic       w_finish;
  logic [7:0] w_result;

  assign w_add_b = r_p[0] ? r_mcand : 4'h0;

  four_bit_full_adder u_adder (
    .a    (r_p[7:4]),
    .b    (w_add_b),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Carry lands in p[7]; the consumed multiplier bit falls off p[0].
  assign w_p_iter = {w_cout, w_sum, r_p[3:1]};

`ifdef SHIFT_ADD_EARLY_EXIT_EN
  logic [2:0] w_live;
  // Only the low 3-cnt bits of p[3:1] are still multiplier bits; the rest are product bits.
  assign w_live   = r_p[3:1] & (3'b111 >> r_cnt);
  assign w_finish = (w_live == 3'b000);
  assign w_result = w_p_iter >> (2'd3 - r_cnt);
`else
  assign w_finish = (r_cnt == 2'd3);
  assign w_result = w_p_iter;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= 4'h0;
      r_p       <= 8'h00;
      r_cnt     <= 2'd0;
      r_product <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_mcand   <= w_mcand_nxt;
      r_p       <= w_p_nxt;
      r_cnt     <= w_cnt_nxt;
      r_product <= w_product_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_mcand_nxt   = r_mcand;
    w_p_nxt       = r_p;
    w_cnt_nxt     = r_cnt;
    w_product_nxt = r_product;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mcand_nxt = a;
          w_p_nxt     = {4'h0, b};
          w_cnt_nxt   = 2'd0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_p_nxt   = w_p_iter;
        w_cnt_nxt = r_cnt + 2'd1;
        if (w_finish) begin
          w_product_nxt = w_result;
          w_state_nxt   = S_DONE;
        end
      end
      S_DONE: begin
        // Leaving DONE doubles as an accept edge so a held start repeats every 5 cycles.
        if (start) begin
          w_mcand_nxt = a;
          w_p_nxt     = {4'h0, b};
          w_cnt_nxt   = 2'd0;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: cycle model plus directed literal checks.
`default_nettype none

module tb_shift_add_multiplier;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int total = 0;
  int bad   = 0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Iterations from accept to completion.
  function automatic int lat(input logic [3:0] bv);
`ifdef SHIFT_ADD_EARLY_EXIT_EN
    int m;
    m = 1;
    for (int i = 0; i < 4; i++) if (bv[i]) m = i + 1;
    return m;
`else
    return 4;
`endif
  endfunction

  // Behavioural model: an accepted op yields a*b after lat(b) edges, with one done cycle.
  int         m_left = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_prod = 8'h00;
  logic [7:0] m_pend = 8'h00;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_prod <= 8'h00;
    end else if (m_left == 0 && start) begin
      m_pend <= 8'(a) * 8'(b);
      m_left <= lat(b);
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_prod <= m_pend;
        m_done <= 1'b1;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  int cyc       = 0;
  int n_done    = 0;
  int last_done = -1;
  bit sweep_on  = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("product", 32'(product), 32'(m_prod));
      if (done === 1'b1) begin
        n_done <= n_done + 1;
`ifndef SHIFT_ADD_EARLY_EXIT_EN
        if (sweep_on && last_done >= 0) check("done_spacing", 32'(cyc - last_done), 32'd5);
`endif
      end
    end
    if (!sweep_on) last_done <= -1;
    else if (chk_en && done === 1'b1) last_done <= cyc;
  end

  task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] exp_p, input int exp_iter);
    int n;
    bit got;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    check("op_done_seen", 32'(got), 32'd1);
    check("op_product", 32'(product), 32'(exp_p));
    check("op_iterations", 32'(n), 32'(exp_iter));
  endtask

  initial begin
    int d0;
    int w;
    rst = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_product", 32'(product), 32'h00);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);

    run_op(4'd15, 4'd15, 8'hE1, 4);
    repeat (3) @(posedge clk);
    #1;
    check("hold_E1", 32'(product), 32'hE1);

    d0 = n_done;
    start = 1'b1; a = 4'd6; b = 4'd3;
    @(posedge clk); #1;
    a = 4'd1; b = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("ignored_start_done_count", 32'(n_done - d0), 32'd1);
    check("ignored_start_product", 32'(product), 32'h12);

    start = 1'b1; a = 4'd9; b = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrun_reset_product", 32'(product), 32'h00);
    check("midrun_reset_busy", 32'(busy), 32'd0);
    d0 = n_done;
    repeat (8) @(posedge clk);
    #1;
    check("midrun_reset_no_done", 32'(n_done - d0), 32'd0);

    d0 = n_done;
    sweep_on = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = 0;
      while (m_left != 0 && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      if (w >= 20) check("sweep_timeout", 32'(w), 32'd0);
      a = 4'(i >> 4);
      b = 4'(i);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    sweep_on = 1'b0;
    check("sweep_done_count", 32'(n_done - d0), 32'd256);

`ifdef SHIFT_ADD_EARLY_EXIT_EN
    run_op(4'd13, 4'd1, 8'h0D, 1);
    run_op(4'd13, 4'd0, 8'h00, 1);
    run_op(4'd13, 4'd4, 8'h34, 3);
`else
    run_op(4'd13, 4'd1, 8'h0D, 4);
    run_op(4'd13, 4'd0, 8'h00, 4);
    run_op(4'd13, 4'd4, 8'h34, 4);
`endif
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
